// File: rtl/instruction_queue_if.sv
// Handshake bundle for instruction_queue: prefetch fill port, decode window and consume port.
// Carries consume_error only when INSTRUCTION_QUEUE_CHECK_EN is defined.
interface instruction_queue_if #(
    parameter int DEPTH = 16
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic             fill_valid;
    logic             fill_ready;
    logic [31:0]      fill_data;
    logic [2:0]       fill_byte_count;
    logic [7:0]       window [0:7];
    logic [3:0]       window_count;
    logic             consume_valid;
    logic [3:0]       consume_length;
    logic [OCC_W-1:0] occupancy;
`ifdef INSTRUCTION_QUEUE_CHECK_EN
    logic             consume_error;

    modport slave (
        input  flush, fill_valid, fill_data, fill_byte_count, consume_valid, consume_length,
        output fill_ready, window, window_count, occupancy, consume_error
    );
    modport master (
        output flush, fill_valid, fill_data, fill_byte_count, consume_valid, consume_length,
        input  fill_ready, window, window_count, occupancy, consume_error
    );
`else
    modport slave (
        input  flush, fill_valid, fill_data, fill_byte_count, consume_valid, consume_length,
        output fill_ready, window, window_count, occupancy
    );
    modport master (
        output flush, fill_valid, fill_data, fill_byte_count, consume_valid, consume_length,
        input  fill_ready, window, window_count, occupancy
    );
`endif
endinterface

// File: rtl/instruction_queue.sv
// Circular byte queue between prefetch and decode, exposing an 8-byte window of the oldest bytes.
// Optional macro INSTRUCTION_QUEUE_CHECK_EN: flag over-length consumes instead of clamping them.
module instruction_queue #(
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    instruction_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [7:0]       r_buf [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_occ;

    logic [3:0]       w_win_count;
    logic             w_fill_ready;
    logic [2:0]       w_fill_n;
    logic [3:0]       w_cons_n;
    logic             w_cons_over;
    logic [OCC_W-1:0] w_occ_next;

    always_comb begin
        w_win_count  = (r_occ > OCC_W'(8)) ? 4'd8 : r_occ[3:0];
        w_fill_ready = (r_occ <= OCC_W'(DEPTH - 4));
        w_cons_over  = (bus.consume_length > w_win_count);

        // Out-of-range byte counts still complete the handshake but write nothing.
        w_fill_n = 3'd0;
        if (bus.fill_valid && w_fill_ready && !bus.flush &&
            bus.fill_byte_count >= 3'd1 && bus.fill_byte_count <= 3'd4)
            w_fill_n = bus.fill_byte_count;

        w_cons_n = 4'd0;
`ifdef INSTRUCTION_QUEUE_CHECK_EN
        if (bus.consume_valid && !w_cons_over && !bus.flush)
            w_cons_n = bus.consume_length;
`else
        if (bus.consume_valid && !bus.flush)
            w_cons_n = w_cons_over ? w_win_count : bus.consume_length;
`endif

        w_occ_next = r_occ + OCC_W'(w_fill_n) - OCC_W'(w_cons_n);
    end

    always_comb begin
        for (int i = 0; i < 8; i++)
            bus.window[i] = (4'(i) < w_win_count) ? r_buf[r_rd_ptr + PTR_W'(i)] : 8'h00;
    end

    assign bus.fill_ready   = w_fill_ready;
    assign bus.window_count = w_win_count;
    assign bus.occupancy    = r_occ;

    // NOTE: the byte array has no reset; emptiness is tracked by the pointers and occupancy alone.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_fill_n)
                r_buf[r_wr_ptr + PTR_W'(k)] <= bus.fill_data[8*k +: 8];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else if (bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_cons_n);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_fill_n);
            r_occ    <= w_occ_next;
        end
    end

`ifdef INSTRUCTION_QUEUE_CHECK_EN
    logic r_consume_error;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_consume_error <= 1'b0;
        else
            r_consume_error <= bus.consume_valid && w_cons_over && !bus.flush;
    end

    assign bus.consume_error = r_consume_error;
`endif
endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed scenarios plus random traffic against a byte-queue model.
module tb_instruction_queue;
    localparam int DEPTH = 16;

    logic clock;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    instruction_queue_if #(.DEPTH(DEPTH)) bus ();

    instruction_queue #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: the queue is simply an ordered list of bytes.
    byte unsigned q[$];
    bit           exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int sz;
        int wc;
        sz = q.size();
        wc = (sz > 8) ? 8 : sz;
        check({tag, "_occ"}, 32'(bus.occupancy), 32'(sz));
        check({tag, "_wcnt"}, 32'(bus.window_count), 32'(wc));
        check({tag, "_rdy"}, 32'(bus.fill_ready), 32'(sz <= DEPTH - 4));
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_win%0d", tag, i), 32'(bus.window[i]), (i < sz) ? 32'(q[i]) : 32'h0);
`ifdef INSTRUCTION_QUEUE_CHECK_EN
        check({tag, "_err"}, 32'(bus.consume_error), 32'(exp_err));
`endif
    endtask

    task automatic drive(input bit fv, input logic [31:0] data, input logic [2:0] cnt,
                         input bit cv, input logic [3:0] len, input bit fl);
        bus.fill_valid      = fv;
        bus.fill_data       = data;
        bus.fill_byte_count = cnt;
        bus.consume_valid   = cv;
        bus.consume_length  = len;
        bus.flush           = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 3'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic model_step();
        int sz;
        int wc;
        bit rdy;
        sz      = q.size();
        wc      = (sz > 8) ? 8 : sz;
        rdy     = (sz <= DEPTH - 4);
        exp_err = 1'b0;
        if (bus.flush) begin
            q.delete();
        end else begin
            if (bus.consume_valid) begin
                if (int'(bus.consume_length) <= wc) begin
                    repeat (int'(bus.consume_length)) void'(q.pop_front());
                end else begin
`ifdef INSTRUCTION_QUEUE_CHECK_EN
                    exp_err = 1'b1;
`else
                    repeat (wc) void'(q.pop_front());
`endif
                end
            end
            if (bus.fill_valid && rdy && bus.fill_byte_count >= 3'd1 && bus.fill_byte_count <= 3'd4)
                for (int k = 0; k < int'(bus.fill_byte_count); k++)
                    q.push_back(bus.fill_data[8*k +: 8]);
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    // Reset is raised between edges and checked before the next edge arrives.
    task automatic async_reset(input string tag);
        idle();
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        exp_err = 1'b0;
        check_all(tag);
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_all({tag, "_rel"});
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #3;
        check_all("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Three 4-byte fills.
        drive(1'b1, 32'h44332211, 3'd4, 1'b0, 4'd0, 1'b0); tick("f1");
        drive(1'b1, 32'h88776655, 3'd4, 1'b0, 4'd0, 1'b0); tick("f2");
        drive(1'b1, 32'hCCBBAA99, 3'd4, 1'b0, 4'd0, 1'b0); tick("f3");
        check("r28_w0", 32'(bus.window[0]), 32'h11);
        check("r28_w7", 32'(bus.window[7]), 32'h88);
        check("r28_occ", 32'(bus.occupancy), 32'd12);

        // Simultaneous consume 3 and fill 4 with 12 queued.
        drive(1'b1, 32'hD3D2D1D0, 3'd4, 1'b1, 4'd3, 1'b0); tick("fc");
        check("r29_w0", 32'(bus.window[0]), 32'h44);
        check("r29_occ", 32'(bus.occupancy), 32'd13);
        check("r29_rdy", 32'(bus.fill_ready), 32'd0);

        // Fill refused while full, consume still applied.
        drive(1'b1, 32'hEEEEEEEE, 3'd4, 1'b1, 4'd1, 1'b0); tick("full");

        // Flush beats a same-cycle fill and consume.
        drive(1'b1, 32'h12345678, 3'd4, 1'b1, 4'd2, 1'b1); tick("flush");
        check("r31_wcnt", 32'(bus.window_count), 32'd0);

        // Walk the pointers to 14, then fill across the wrap.
        async_reset("rst1");
        drive(1'b1, 32'h0000BBAA, 3'd2, 1'b0, 4'd0, 1'b0); tick("w_f2");
        drive(1'b0, 32'h0, 3'd0, 1'b1, 4'd2, 1'b0);        tick("w_c2");
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, $urandom, 3'd4, 1'b0, 4'd0, 1'b0); tick("w_f4");
            drive(1'b0, 32'h0, 3'd0, 1'b1, 4'd4, 1'b0);    tick("w_c4");
        end
        drive(1'b1, 32'h01F0EEDD, 3'd4, 1'b0, 4'd0, 1'b0); tick("wrap");
        check("r30_w0", 32'(bus.window[0]), 32'hDD);
        check("r30_w3", 32'(bus.window[3]), 32'h01);
        drive(1'b1, 32'h05040302, 3'd4, 1'b1, 4'd1, 1'b0); tick("wrap2");

        // Illegal byte counts handshake but write nothing.
        drive(1'b1, 32'hFFFFFFFF, 3'd0, 1'b0, 4'd0, 1'b0); tick("cnt0");
        drive(1'b1, 32'hFFFFFFFF, 3'd5, 1'b0, 4'd0, 1'b0); tick("cnt5");

        // Over-length consume with 5 bytes queued.
        async_reset("rst2");
        drive(1'b1, 32'h44332211, 3'd4, 1'b0, 4'd0, 1'b0); tick("o_f4");
        drive(1'b1, 32'h00000055, 3'd1, 1'b0, 4'd0, 1'b0); tick("o_f1");
        drive(1'b0, 32'h0, 3'd0, 1'b1, 4'd6, 1'b0);        tick("over");
`ifdef INSTRUCTION_QUEUE_CHECK_EN
        check("r32_occ", 32'(bus.occupancy), 32'd5);
        check("r32_err", 32'(bus.consume_error), 32'd1);
`else
        check("r32_occ", 32'(bus.occupancy), 32'd0);
`endif
        idle(); tick("over_after");

        // Nine bytes queued, then asynchronous reset mid-cycle.
        drive(1'b1, 32'h44332211, 3'd4, 1'b0, 4'd0, 1'b0); tick("n_f1");
        drive(1'b1, 32'h88776655, 3'd4, 1'b0, 4'd0, 1'b0); tick("n_f2");
        drive(1'b1, 32'h00000099, 3'd1, 1'b0, 4'd0, 1'b0); tick("n_f3");
        async_reset("r33");
        check("r33_occ", 32'(bus.occupancy), 32'd0);
        check("r33_rdy", 32'(bus.fill_ready), 32'd1);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom,
                  ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4)),
                  $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 9)),
                  $urandom_range(0, 39) == 0);
            tick("rnd");
            if (n == 700)
                async_reset("rnd_rst");
        end

        idle();
        tick("end");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
